// File: rtl/traffic_light_fsm.sv
// Two-road signal sequencer driven by traffic_timer done pulses, with pedestrian
// request latching and a watchdog that latches a flashing-yellow fault mode.
module traffic_light_fsm #(
  parameter int unsigned WDOG_CYCLES = 1023,
  parameter int unsigned FLASH_DIV   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_pulse,
  input  logic       ped_req,
  output logic       timer_select,
  output logic       timer_restart,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned FW = $clog2(FLASH_DIV + 1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    RED_A  = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    RED_B  = 3'd5,
    FAULT  = 3'd7
  } state_t;

  state_t          state, state_n;
  logic            started, started_n;
  logic [WW-1:0]   wdog, wdog_n;
  logic [FW-1:0]   flash_cnt, flash_n;
  logic            flash_on, flash_on_n;
  logic            ped_d, ped_lat, ped_lat_n;
  logic            entry;
  logic            select_n, restart_n, walk_n, fault_n;
  logic [2:0]      ns_n, ew_n;

  always_comb begin
    state_n    = state;
    started_n  = 1'b1;
    wdog_n     = wdog;
    flash_n    = flash_cnt;
    flash_on_n = flash_on;
    ped_lat_n  = ped_lat;
    entry      = 1'b0;

    if (state == FAULT) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_n    = '0;
        flash_on_n = ~flash_on;
      end else begin
        flash_n = flash_cnt + 1'b1;
      end
    end else begin
      // The first clock after reset counts as entry into RED_B.
      if (!started) begin
        entry = 1'b1;
      end else if (done_pulse) begin
        entry = 1'b1;
        case (state)
          NS_GRN:  state_n = NS_YEL;
          NS_YEL:  state_n = RED_A;
          RED_A:   state_n = EW_GRN;
          EW_GRN:  state_n = EW_YEL;
          EW_YEL:  state_n = RED_B;
          default: state_n = NS_GRN;
        endcase
      end else if (wdog == WDOG_LAST) begin
        state_n    = FAULT;
        flash_n    = '0;
        flash_on_n = 1'b1;
      end else begin
        wdog_n = wdog + 1'b1;
      end
      if (entry) wdog_n = '0;
      // A new press in the same cycle as the NS_GRN clear survives for the next NS_GRN.
      ped_lat_n = (ped_req & ~ped_d) | (ped_lat & ~(entry & (state_n == NS_GRN)));
    end

    restart_n = entry;
    select_n  = (state_n == NS_GRN) || (state_n == EW_GRN);
    fault_n   = (state_n == FAULT);
    walk_n    = 1'b0;
    if (state_n == NS_GRN) walk_n = entry ? ped_lat : ped_walk;

    ns_n = L_RED;
    ew_n = L_RED;
    case (state_n)
      NS_GRN: ns_n = L_GRN;
      NS_YEL: ns_n = L_YEL;
      EW_GRN: ew_n = L_GRN;
      EW_YEL: ew_n = L_YEL;
      FAULT: begin
        ns_n = flash_on_n ? L_YEL : L_OFF;
        ew_n = flash_on_n ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RED_B;
      started       <= 1'b0;
      wdog          <= '0;
      flash_cnt     <= '0;
      flash_on      <= 1'b0;
      ped_d         <= 1'b0;
      ped_lat       <= 1'b0;
      timer_select  <= 1'b0;
      timer_restart <= 1'b0;
      ns_light      <= L_RED;
      ew_light      <= L_RED;
      ped_walk      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      started       <= started_n;
      wdog          <= wdog_n;
      flash_cnt     <= flash_n;
      flash_on      <= flash_on_n;
      ped_d         <= ped_req;
      ped_lat       <= ped_lat_n;
      timer_select  <= select_n;
      timer_restart <= restart_n;
      ns_light      <= ns_n;
      ew_light      <= ew_n;
      ped_walk      <= walk_n;
      fault         <= fault_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: a cycle-level reference model predicts
// every post-edge output word, a monitor compares the DUT against the queue.
module tb_traffic_light_fsm;

  localparam int unsigned WDOG = 24;
  localparam int unsigned FDIV = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       ts;
    logic       rs;
    logic       wk;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_pulse = 1'b0;
  logic       ped_req = 1'b0;
  logic       timer_select, timer_restart, ped_walk, fault;
  logic [2:0] ns_light, ew_light, state_dbg;

  traffic_light_fsm #(.WDOG_CYCLES(WDOG), .FLASH_DIV(FDIV)) dut (
    .clk(clk), .rst(rst), .done_pulse(done_pulse), .ped_req(ped_req),
    .timer_select(timer_select), .timer_restart(timer_restart),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase index around a six-step ring, plus counters of
  // cycles spent in the phase and cycles spent in the fault.
  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int   m_phase, m_since, m_flash;
  bit   m_faulted, m_started, m_pend, m_walk, m_prev;

  task automatic model_reset();
    m_phase = 5; m_since = 0; m_flash = 0;
    m_faulted = 0; m_started = 0; m_pend = 0; m_walk = 0; m_prev = 0;
  endtask

  task automatic push_reset();
    exp_t e;
    e = '{st: 3'd5, ns: 3'b100, ew: 3'b100, ts: 1'b0, rs: 1'b0, wk: 1'b0, ft: 1'b0};
    q.push_back(e);
  endtask

  task automatic predict(input bit d, input bit p);
    exp_t e;
    bit   enter, rise;
    rise   = p && !m_prev;
    m_prev = p;
    enter  = 0;
    if (m_faulted) m_flash++;
    else if (!m_started) begin m_started = 1; enter = 1; end
    else if (d) begin m_phase = (m_phase + 1) % 6; enter = 1; end
    else if (m_since + 1 == WDOG) begin m_faulted = 1; m_flash = 0; end
    else m_since++;
    if (enter) begin
      m_since = 0;
      if (m_phase == 0) begin m_walk = m_pend; m_pend = 0; end
      else m_walk = 0;
    end
    if (!m_faulted && rise) m_pend = 1;
    if (m_faulted) begin
      e.st = 3'd7;
      e.ns = ((m_flash / FDIV) % 2 == 0) ? 3'b010 : 3'b000;
      e.ew = e.ns;
      e.ts = 0; e.rs = 0; e.wk = 0; e.ft = 1;
    end else begin
      e.st = 3'(m_phase);
      e.ns = ns_tab[m_phase];
      e.ew = ew_tab[m_phase];
      e.ts = (m_phase == 0 || m_phase == 3);
      e.rs = enter;
      e.wk = m_walk;
      e.ft = 0;
    end
    q.push_back(e);
  endtask

  // Inputs change 4 ns after each rising edge; the monitor looks 2 ns after.
  task automatic step(input bit d, input bit p);
    @(posedge clk); #4;
    rst = 1'b1; done_pulse = d; ped_req = p;
    predict(d, p);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #4;
    rst = 1'b0; done_pulse = 1'b0; ped_req = 1'b0;
    model_reset();
    push_reset();
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #4;
      push_reset();
    end
  endtask

  task automatic run_gap(input int g, input bit rnd_ped);
    for (int c = 1; c <= g; c++)
      step(c == g, rnd_ped ? ($urandom_range(0, 7) == 0) : 1'b0);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk or negedge rst);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{st: state_dbg, ns: ns_light, ew: ew_light, ts: timer_select,
              rs: timer_restart, wk: ped_walk, ft: fault};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t actual st=%0d ns=%b ew=%b sel=%b rst=%b walk=%b flt=%b required st=%0d ns=%b ew=%b sel=%b rst=%b walk=%b flt=%b",
                   $time, a.st, a.ns, a.ew, a.ts, a.rs, a.wk, a.ft,
                   e.st, e.ns, e.ew, e.ts, e.rs, e.wk, e.ft);
        end
      end
    end
  end

  initial begin : stimulus
    model_reset();
    do_reset(2);
    step(0, 0);
    repeat (5) step(0, 0);

    // Two laps of 20-cycle phases; presses during EW_GRN and at NS_GRN entry.
    for (int k = 0; k < 12; k++) begin
      for (int c = 1; c <= 20; c++)
        step(c == 20, (m_phase == 3 && c >= 5 && c <= 7) || (m_phase == 5 && c == 20 && k >= 6));
    end

    // done_pulse arriving exactly on the watchdog expiry cycle.
    run_gap(WDOG, 1'b0);
    run_gap(WDOG, 1'b1);

    for (int k = 0; k < 40; k++)
      run_gap($urandom_range(1, WDOG), 1'b1);

    // Reset asserted partway through EW_YEL.
    for (int k = 0; k < 8 && m_phase != 4; k++) step(1, 0);
    repeat (3) step(0, 0);
    do_reset(2);
    step(0, 0);
    run_gap(3, 1'b0);

    // Starve the watchdog, then show done/ped are ignored while flashing.
    repeat (WDOG + 3) step(0, 0);
    repeat (FDIV * 6) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    do_reset(3);
    step(0, 0);
    run_gap(5, 1'b0);

    repeat (2) @(posedge clk);
    #4;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain actual %0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
